// File: rtl/mdu_iter_pkg.sv
// Shared op and state encodings for the iterative multiply/divide unit.
package mdu_iter_pkg;

  typedef logic [1:0] mdu_op_t;

  localparam mdu_op_t OP_MULT  = 2'b00;
  localparam mdu_op_t OP_MULTU = 2'b01;
  localparam mdu_op_t OP_DIV   = 2'b10;
  localparam mdu_op_t OP_DIVU  = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  function automatic logic opIsDiv(input mdu_op_t op);
    return op[1];
  endfunction

  function automatic logic opIsSigned(input mdu_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the datapath controller and the multiply/divide unit.
interface mdu_iter_if
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, abort, wr_hi, wr_lo, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, abort, wr_hi, wr_lo, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architecturally visible HI/LO registers.
// One shared WIDTH+1-bit add/subtract step per cycle; signs are fixed up in a final cycle.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  mdu_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         r_state;
  logic               r_isDiv;
  logic               r_sa;
  logic               r_sb;
  logic               r_bZero;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_accHi;
  logic [WIDTH-1:0]   r_accLo;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_aOrig;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz;

  logic               w_accept;
  logic               w_signA;
  logic               w_signB;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic               w_sub;
  logic [WIDTH:0]     w_opA;
  logic [WIDTH:0]     w_opB;
  logic [WIDTH+1:0]   w_sum;
  logic [WIDTH-1:0]   w_nextHi;
  logic [WIDTH-1:0]   w_nextLo;
  logic [2*WIDTH-1:0] w_prodNeg;
  logic [WIDTH-1:0]   w_fixHi;
  logic [WIDTH-1:0]   w_fixLo;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_signA  = opIsSigned(bus.op) && bus.a[WIDTH-1];
  assign w_signB  = opIsSigned(bus.op) && bus.b[WIDTH-1];
  assign w_absA   = w_signA ? -bus.a : bus.a;
  assign w_absB   = w_signB ? -bus.b : bus.b;

  // Divide subtracts the divisor from the shifted remainder; multiply adds the
  // multiplicand only when the current multiplier bit is set.
  always_comb begin
    w_sub = r_isDiv;
    w_opA = {1'b0, r_accHi};
    w_opB = {1'b0, r_divisor};
    if (r_isDiv) begin
      w_opA = {r_accHi, r_accLo[WIDTH-1]};
    end else if (!r_accLo[0]) begin
      w_opB = '0;
    end
  end

  assign w_sum = {1'b0, w_opA} + {1'b0, (w_sub ? ~w_opB : w_opB)} + {{(WIDTH+1){1'b0}}, w_sub};

  // The top sum bit is the no-borrow flag for divide, which is also the quotient bit.
  always_comb begin
    if (r_isDiv) begin
      w_nextHi = w_sum[WIDTH+1] ? w_sum[WIDTH-1:0] : w_opA[WIDTH-1:0];
      w_nextLo = {r_accLo[WIDTH-2:0], w_sum[WIDTH+1]};
    end else begin
      w_nextHi = w_sum[WIDTH:1];
      w_nextLo = {w_sum[0], r_accLo[WIDTH-1:1]};
    end
  end

  assign w_prodNeg = -{r_accHi, r_accLo};

  always_comb begin
    w_fixHi = r_accHi;
    w_fixLo = r_accLo;
    if (!r_isDiv) begin
      if (r_sa ^ r_sb) begin
        {w_fixHi, w_fixLo} = w_prodNeg;
      end
    end else if (r_bZero) begin
      w_fixHi = r_aOrig;
      w_fixLo = '1;
    end else begin
      if (r_sa ^ r_sb) w_fixLo = -r_accLo;
      if (r_sa)        w_fixHi = -r_accHi;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_isDiv   <= 1'b0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_bZero   <= 1'b0;
      r_count   <= '0;
      r_accHi   <= '0;
      r_accLo   <= '0;
      r_divisor <= '0;
      r_aOrig   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= RUN;
            r_isDiv   <= opIsDiv(bus.op);
            r_sa      <= w_signA;
            r_sb      <= w_signB;
            r_bZero   <= (bus.b == '0);
            r_count   <= CW'(WIDTH);
            r_accHi   <= '0;
            r_accLo   <= w_absA;
            r_divisor <= w_absB;
            r_aOrig   <= bus.a;
          end
        end
        RUN: begin
          if (bus.abort) begin
            r_state <= IDLE;
          end else begin
            r_accHi <= w_nextHi;
            r_accLo <= w_nextLo;
            r_count <= r_count - 1'b1;
            if (r_count == CW'(1)) r_state <= FIX;
          end
        end
        FIX:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // HI/LO change only on a completed operation or an idle MTHI/MTLO write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= (r_state == FIX) && !bus.abort;
      r_dbz  <= (r_state == FIX) && !bus.abort && r_isDiv && r_bZero;
      if ((r_state == FIX) && !bus.abort) begin
        r_hi <= w_fixHi;
        r_lo <= w_fixLo;
      end else if ((r_state == IDLE) && !bus.start) begin
        if (bus.wr_hi) r_hi <= bus.wr_data;
        if (bus.wr_lo) r_lo <= bus.wr_data;
      end
    end
  end

  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

endmodule
